// File: rtl/nor_array_if.sv
// Bus bundle for nor_array: gate inputs and freeze control toward the block,
// gate outputs and status back from it.
interface nor_array_if #(
  parameter int CHANNELS = 4,
  parameter int FANIN    = 3
);
  logic                        hold;
  logic [CHANNELS*FANIN-1:0]   a;
  logic [CHANNELS-1:0]         y;
  logic                        chg;
  logic                        settled;

  modport master (
    output hold,
    output a,
    input  y,
    input  chg,
    input  settled
  );

  modport slave (
    input  hold,
    input  a,
    output y,
    output chg,
    output settled
  );
endinterface

// File: rtl/nor_array.sv
// Bank of CHANNELS independent FANIN-input NOR gates with a DEPTH-stage
// clocked propagation delay. Inputs are captured on the falling edge and the
// delay line advances on the rising edge, so a DEPTH=1 instance behaves like a
// classic half-cycle gate. A freeze input stalls the whole block, and change /
// settle status lets a cluster of these be stepped and observed as one unit.
module nor_array #(
  parameter int                  CHANNELS      = 4,
  parameter int                  FANIN         = 3,
  parameter int                  DEPTH         = 1,
  parameter logic [CHANNELS-1:0] IV            = '0,
  parameter int                  SETTLE_CYCLES = 4
) (
  input  logic      clk,
  input  logic      rst,
  nor_array_if.slave bus
);

  localparam int                CNT_W   = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  // Quiet-time counter step: counts up and parks at the settle threshold.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic [CHANNELS-1:0] nor_p0;
  logic [CHANNELS-1:0] s0_p0;
  logic [CHANNELS-1:0] pipe_p [1:DEPTH];
  logic [CHANNELS-1:0] src_p  [1:DEPTH];
  logic                y_chg;
  logic                chg_q;
  logic [CNT_W-1:0]    cnt_q;

  // Per-channel NOR of that channel's own input slice only.
  always_comb begin
    nor_p0 = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      nor_p0[c] = ~|bus.a[c*FANIN +: FANIN];
    end
  end

  // Stage 0: falling-edge capture of the gate outputs.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      s0_p0 <= IV;
    end else if (!bus.hold) begin
      s0_p0 <= nor_p0;
    end
  end

  // Source of each rising-edge stage: stage 1 takes the capture register,
  // every later stage takes its predecessor.
  assign src_p[1] = s0_p0;
  for (genvar k = 2; k <= DEPTH; k++) begin : g_src
    assign src_p[k] = pipe_p[k-1];
  end

  // The value about to land on y differs from the one currently shown.
  always_comb y_chg = (src_p[DEPTH] != pipe_p[DEPTH]);

  // Stages 1..DEPTH: rising-edge delay line plus change/settle bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++) begin
        pipe_p[k] <= IV;
      end
      chg_q <= 1'b0;
      cnt_q <= '0;
    end else if (bus.hold) begin
      chg_q <= 1'b0;
    end else begin
      for (int k = 1; k <= DEPTH; k++) begin
        pipe_p[k] <= src_p[k];
      end
      chg_q <= y_chg;
      cnt_q <= y_chg ? '0 : sat_inc(cnt_q);
    end
  end

  assign bus.y       = pipe_p[DEPTH];
  assign bus.chg     = chg_q;
  assign bus.settled = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_nor_array.sv
// Testbench for nor_array: directed scenarios on a 4x3-input, depth-2 instance
// plus a randomized run against a queue-based reference model, and a
// degenerate single-inverter instance.
module tb_nor_array;

  localparam int         CH  = 4;
  localparam int         FI  = 3;
  localparam int         DP  = 2;
  localparam int         SC  = 3;
  localparam logic [3:0] IVV = 4'b1010;

  logic clk = 1'b0;
  logic rst = 1'b1;

  nor_array_if #(.CHANNELS(CH), .FANIN(FI)) bus ();
  nor_array_if #(.CHANNELS(1),  .FANIN(1))  bus1 ();

  nor_array #(
    .CHANNELS(CH), .FANIN(FI), .DEPTH(DP), .IV(IVV), .SETTLE_CYCLES(SC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  nor_array #(
    .CHANNELS(1), .FANIN(1), .DEPTH(1), .IV(1'b1), .SETTLE_CYCLES(2)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: samples waiting in a FIFO of DEPTH-1 entries, y separate.
  logic [3:0] m_s0;
  logic [3:0] m_y;
  logic [3:0] m_q [$];
  logic       m_chg;
  int         m_cnt;
  logic       samp1;

  function automatic logic [3:0] ref_nor(input logic [11:0] v);
    logic [3:0] r;
    for (int c = 0; c < CH; c++) r[c] = (((v >> (c * FI)) & 12'h7) == 12'h0);
    return r;
  endfunction

  task automatic model_reset();
    m_s0 = IVV;
    m_q.delete();
    for (int i = 0; i < DP - 1; i++) m_q.push_back(IVV);
    m_y   = IVV;
    m_chg = 1'b0;
    m_cnt = 0;
  endtask

  always @(negedge clk) begin
    if (!rst && !bus.hold) m_s0 = ref_nor(bus.a);
    if (!rst) samp1 = bus1.a[0];
  end

  always @(posedge clk) begin : model_upd
    logic [3:0] nx;
    if (!rst) begin
      if (bus.hold) begin
        m_chg = 1'b0;
      end else begin
        m_q.push_back(m_s0);
        nx    = m_q.pop_front();
        m_chg = (nx !== m_y);
        if (m_chg) m_cnt = 0;
        else if (m_cnt < SC) m_cnt++;
        m_y = nx;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    #12;
    n_chk++; if (bus.y !== IVV) begin n_fail++; $display("FAIL reset_y: got %b expected %b", bus.y, IVV); end
    n_chk++; if (bus.chg !== 1'b0) begin n_fail++; $display("FAIL reset_chg: got %b expected 0", bus.chg); end
    n_chk++; if (bus.settled !== 1'b0) begin n_fail++; $display("FAIL reset_settled: got %b expected 0", bus.settled); end
    n_chk++; if (bus1.y !== 1'b1) begin n_fail++; $display("FAIL reset_y1: got %b expected 1", bus1.y); end
    @(posedge clk); #2;
    bus.a = 12'h208;
    rst   = 1'b0;
    step(); step();
    n_chk++; if (bus.y !== 4'b0101) begin n_fail++; $display("FAIL pre_rst_y: got %b expected 0101", bus.y); end
    n_chk++; if (bus.chg !== 1'b1) begin n_fail++; $display("FAIL pre_rst_chg: got %b expected 1", bus.chg); end
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    n_chk++; if (bus.y !== IVV) begin n_fail++; $display("FAIL async_rst_y: got %b expected %b", bus.y, IVV); end
    n_chk++; if (bus.chg !== 1'b0) begin n_fail++; $display("FAIL async_rst_chg: got %b expected 0", bus.chg); end
    n_chk++; if (bus.settled !== 1'b0) begin n_fail++; $display("FAIL async_rst_settled: got %b expected 0", bus.settled); end
  endtask

  task automatic test_latency();
    bus.a = '0;
    rst   = 1'b0;
    step();
    n_chk++; if (bus.y !== IVV) begin n_fail++; $display("FAIL lat_p1_y: got %b expected %b", bus.y, IVV); end
    n_chk++; if (bus.chg !== 1'b0) begin n_fail++; $display("FAIL lat_p1_chg: got %b expected 0", bus.chg); end
    step();
    n_chk++; if (bus.y !== 4'b1111) begin n_fail++; $display("FAIL lat_p2_y: got %b expected 1111", bus.y); end
    n_chk++; if (bus.chg !== 1'b1) begin n_fail++; $display("FAIL lat_p2_chg: got %b expected 1", bus.chg); end
    step();
    n_chk++; if (bus.chg !== 1'b0) begin n_fail++; $display("FAIL lat_p3_chg: got %b expected 0", bus.chg); end
    n_chk++; if (bus.settled !== 1'b0) begin n_fail++; $display("FAIL lat_p3_settled: got %b expected 0", bus.settled); end
    step();
    n_chk++; if (bus.settled !== 1'b0) begin n_fail++; $display("FAIL lat_p4_settled: got %b expected 0", bus.settled); end
    step();
    n_chk++; if (bus.settled !== 1'b1) begin n_fail++; $display("FAIL lat_p5_settled: got %b expected 1", bus.settled); end
  endtask

  task automatic test_isolation();
    bus.a = 12'h040;
    step();
    n_chk++; if (bus.y !== 4'b1111) begin n_fail++; $display("FAIL iso_p1_y: got %b expected 1111", bus.y); end
    n_chk++; if (bus.settled !== 1'b1) begin n_fail++; $display("FAIL iso_p1_settled: got %b expected 1", bus.settled); end
    step();
    n_chk++; if (bus.y !== 4'b1011) begin n_fail++; $display("FAIL iso_p2_y: got %b expected 1011", bus.y); end
    n_chk++; if (bus.chg !== 1'b1) begin n_fail++; $display("FAIL iso_p2_chg: got %b expected 1", bus.chg); end
    n_chk++; if (bus.settled !== 1'b0) begin n_fail++; $display("FAIL iso_p2_settled: got %b expected 0", bus.settled); end
    step();
    n_chk++; if (bus.chg !== 1'b0) begin n_fail++; $display("FAIL iso_p3_chg: got %b expected 0", bus.chg); end
  endtask

  task automatic test_hold();
    logic sv_settled;
    sv_settled = bus.settled;
    bus.hold = 1'b1;
    bus.a    = '1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_chk++; if (bus.y !== 4'b1011) begin n_fail++; $display("FAIL hold_y[%0d]: got %b expected 1011", i, bus.y); end
      n_chk++; if (bus.chg !== 1'b0) begin n_fail++; $display("FAIL hold_chg[%0d]: got %b expected 0", i, bus.chg); end
      n_chk++; if (bus.settled !== sv_settled) begin n_fail++; $display("FAIL hold_settled[%0d]: got %b expected %b", i, bus.settled, sv_settled); end
    end
    bus.hold = 1'b0;
    step();
    n_chk++; if (bus.y !== 4'b1011) begin n_fail++; $display("FAIL unhold_p1_y: got %b expected 1011", bus.y); end
    step();
    n_chk++; if (bus.y !== 4'b0000) begin n_fail++; $display("FAIL unhold_p2_y: got %b expected 0000", bus.y); end
    n_chk++; if (bus.chg !== 1'b1) begin n_fail++; $display("FAIL unhold_p2_chg: got %b expected 1", bus.chg); end
  endtask

  task automatic test_reset_mid();
    bus.a = '0;
    step();
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    n_chk++; if (bus.y !== IVV) begin n_fail++; $display("FAIL mid_rst_y: got %b expected %b", bus.y, IVV); end
    n_chk++; if (bus.chg !== 1'b0) begin n_fail++; $display("FAIL mid_rst_chg: got %b expected 0", bus.chg); end
    bus.a = 12'h208;
    rst   = 1'b0;
    step();
    n_chk++; if (bus.y !== IVV) begin n_fail++; $display("FAIL mid_p1_y: got %b expected %b", bus.y, IVV); end
    n_chk++; if (bus.chg !== 1'b0) begin n_fail++; $display("FAIL mid_p1_chg: got %b expected 0", bus.chg); end
    step();
    n_chk++; if (bus.y !== 4'b0101) begin n_fail++; $display("FAIL mid_p2_y: got %b expected 0101", bus.y); end
    n_chk++; if (bus.chg !== 1'b1) begin n_fail++; $display("FAIL mid_p2_chg: got %b expected 1", bus.chg); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step();
      n_chk++; if (bus.y !== m_y) begin n_fail++; $display("FAIL rnd_y[%0d]: got %b expected %b", i, bus.y, m_y); end
      n_chk++; if (bus.chg !== m_chg) begin n_fail++; $display("FAIL rnd_chg[%0d]: got %b expected %b", i, bus.chg, m_chg); end
      n_chk++; if (bus.settled !== (m_cnt == SC)) begin n_fail++; $display("FAIL rnd_settled[%0d]: got %b expected %b", i, bus.settled, (m_cnt == SC)); end
      if ($urandom_range(0, 3) == 0) bus.a = 12'($urandom & $urandom & $urandom);
      bus.hold = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 49) == 0) begin
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        n_chk++; if (bus.y !== IVV) begin n_fail++; $display("FAIL rnd_rst_y[%0d]: got %b expected %b", i, bus.y, IVV); end
        rst = 1'b0;
      end
    end
    bus.hold = 1'b0;
  endtask

  task automatic test_degenerate();
    for (int i = 0; i < 20; i++) begin
      bus1.a = ~bus1.a;
      step();
      n_chk++; if (bus1.y !== ~samp1) begin n_fail++; $display("FAIL deg_y[%0d]: got %b expected %b", i, bus1.y, ~samp1); end
      n_chk++; if (bus1.settled !== 1'b0) begin n_fail++; $display("FAIL deg_settled[%0d]: got %b expected 0", i, bus1.settled); end
      n_chk++; if (bus1.chg !== 1'b1) begin n_fail++; $display("FAIL deg_chg[%0d]: got %b expected 1", i, bus1.chg); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.hold  = 1'b0;
    bus.a     = '0;
    bus1.hold = 1'b0;
    bus1.a    = '0;
    samp1     = 1'b0;
    model_reset();
    test_reset();
    test_latency();
    test_isolation();
    test_hold();
    test_reset_mid();
    test_random();
    test_degenerate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
